// File: rtl/fifo_dispatch_arbiter_if.sv
// Handshake bundle between the ingress FIFO bank, the dispatch arbiter and the egress FIFO bank.
// master is the arbiter side; slave is the FIFO-bank side.
interface fifo_dispatch_arbiter_if #(
    parameter int unsigned WORD_SIZE = 10,
    parameter int unsigned PTR       = 3
);
    logic [3:0]           in_empty;
    logic [WORD_SIZE-1:0] in_data0;
    logic [WORD_SIZE-1:0] in_data1;
    logic [WORD_SIZE-1:0] in_data2;
    logic [WORD_SIZE-1:0] in_data3;
    logic [3:0]           in_pop;
    logic [3:0]           out_almost_full;
    logic [3:0]           out_push;
    logic [WORD_SIZE-1:0] out_data;
    logic [1:0]           grant;
    logic                 idle;
    logic [PTR+4:0]       fwd_count;

    modport master (
        input  in_empty,
        input  in_data0,
        input  in_data1,
        input  in_data2,
        input  in_data3,
        input  out_almost_full,
        output in_pop,
        output out_push,
        output out_data,
        output grant,
        output idle,
        output fwd_count
    );

    modport slave (
        output in_empty,
        output in_data0,
        output in_data1,
        output in_data2,
        output in_data3,
        output out_almost_full,
        input  in_pop,
        input  out_push,
        input  out_data,
        input  grant,
        input  idle,
        input  fwd_count
    );
endinterface

// File: rtl/fifo_dispatch_arbiter.sv
// Pops one word per cycle from four ingress FIFOs and routes it to the egress FIFO named by its MSBs.
// Define ARB_ROUND_ROBIN_EN for round-robin source selection; otherwise lowest index wins.
module fifo_dispatch_arbiter #(
    parameter int unsigned WORD_SIZE = 10,
    parameter int unsigned PTR       = 3
) (
    input logic                  clk,
    input logic                  reset,
    fifo_dispatch_arbiter_if.master bus
);

    localparam int unsigned CntW = PTR + 5;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StActive
    } state_e;

    state_e               state_q, state_d;
    logic                 v1_q, v1_d;
    logic [1:0]           src_q, src_d;
    logic [3:0]           out_push_q, out_push_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic [1:0]           grant_q, grant_d;
    logic [CntW-1:0]      fwd_count_q, fwd_count_d;

    logic [3:0]           avail;
    logic                 any_avail;
    logic                 stall;
    logic                 pop_en;
    logic [1:0]           sel;
    logic [WORD_SIZE-1:0] stage_data;
    logic [1:0]           dest;

    assign avail     = ~bus.in_empty;
    assign any_avail = |avail;
    // Destination is unknown until data returns, so any almost_full stalls every source.
    assign stall     = |bus.out_almost_full;
    assign pop_en    = (state_q == StActive) && any_avail && !stall;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        logic [1:0] idx;
        logic       found;
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = rr_ptr_q;
        // k = 4 wraps back onto the pointer itself, so the last grant is checked last.
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && avail[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop_en) begin
            rr_ptr_d = sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 2'd3;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (avail[k]) begin
                sel = 2'(k);
            end
        end
    end
`endif

    // Stage 1: the popped FIFO presents its word one cycle after the pop.
    always_comb begin
        stage_data = bus.in_data0;
        unique case (src_q)
            2'd0: stage_data = bus.in_data0;
            2'd1: stage_data = bus.in_data1;
            2'd2: stage_data = bus.in_data2;
            2'd3: stage_data = bus.in_data3;
            default: stage_data = bus.in_data0;
        endcase
    end

    assign dest = stage_data[WORD_SIZE-1 -: 2];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                state_d = StIdle;
            end
            StIdle: begin
                if (any_avail) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!any_avail && !v1_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_comb begin
        v1_d        = pop_en;
        src_d       = pop_en ? sel : src_q;
        grant_d     = pop_en ? sel : grant_q;
        out_push_d  = 4'b0000;
        out_data_d  = out_data_q;
        fwd_count_d = fwd_count_q;
        if (v1_q) begin
            out_push_d  = 4'b0001 << dest;
            out_data_d  = stage_data;
            fwd_count_d = fwd_count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StInit;
            v1_q        <= 1'b0;
            src_q       <= 2'd0;
            grant_q     <= 2'd0;
            out_push_q  <= 4'b0000;
            out_data_q  <= '0;
            fwd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            v1_q        <= v1_d;
            src_q       <= src_d;
            grant_q     <= grant_d;
            out_push_q  <= out_push_d;
            out_data_q  <= out_data_d;
            fwd_count_q <= fwd_count_d;
        end
    end

    assign bus.in_pop    = pop_en ? (4'b0001 << sel) : 4'b0000;
    assign bus.grant     = pop_en ? sel : grant_q;
    assign bus.out_push  = out_push_q;
    assign bus.out_data  = out_data_q;
    assign bus.idle      = (state_q == StIdle);
    assign bus.fwd_count = fwd_count_q;

endmodule

// File: tb/tb_fifo_dispatch_arbiter.sv
// Directed bench for fifo_dispatch_arbiter with a queue-based FIFO/routing model checked every cycle.
module tb_fifo_dispatch_arbiter;

    logic clk;
    logic reset;

    fifo_dispatch_arbiter_if #(.WORD_SIZE(10), .PTR(3)) bus ();

    fifo_dispatch_arbiter #(.WORD_SIZE(10), .PTR(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [9:0] w;
    } pend_t;

    logic [9:0] fq [4][$];
    logic [9:0] dreg [4];
    logic [3:0] empt;
    logic [3:0] afull;
    logic [3:0] pop_lat;
    pend_t      pend [$];
    logic [7:0] mcnt;
    int         mptr;
    int         cyc;
    int         nvec;
    int         nfail;

    assign bus.in_empty        = empt;
    assign bus.out_almost_full = afull;
    assign bus.in_data0        = dreg[0];
    assign bus.in_data1        = dreg[1];
    assign bus.in_data2        = dreg[2];
    assign bus.in_data3        = dreg[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) empt[i] = (fq[i].size() == 0);
    endtask

    task automatic load(input int i, input logic [9:0] w);
        fq[i].push_back(w);
        refresh();
    endtask

    // Which FIFO the arbitration rule says should be served, or -1 if all are empty.
    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (fq[(mptr + k) % 4].size() > 0) return (mptr + k) % 4;
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (fq[i].size() > 0) return i;
        end
`endif
        return -1;
    endfunction

    // Per-cycle compare against the model, run at every falling edge.
    task automatic model_check();
        logic [9:0] w;
        logic [3:0] ep;
        int         ec;
        cyc++;
        if (!reset) begin
            pend.delete();
            mcnt    = 8'd0;
            mptr    = 3;
            pop_lat = 4'b0000;
            chk("rst_pop", bus.in_pop, 0);
            chk("rst_push", bus.out_push, 0);
            chk("rst_count", bus.fwd_count, 0);
            return;
        end
        ep = 4'b0000;
        w  = 10'd0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            w  = pend[0].w;
            void'(pend.pop_front());
            ep   = 4'b0001 << w[9:8];
            mcnt = mcnt + 8'd1;
        end
        chk("push", bus.out_push, ep);
        if (ep != 4'b0000) chk("data", bus.out_data, w);
        chk("count", bus.fwd_count, mcnt);
        if (bus.in_pop != 4'b0000) begin
            ec = pick();
            chk("pop_sel", bus.in_pop,
                (ec >= 0 && afull == 4'b0000) ? (32'd1 << ec) : 32'd0);
            if (ec >= 0 && afull == 4'b0000) begin
                chk("grant", bus.grant, ec);
                pend.push_back('{due: cyc + 2, w: fq[ec][0]});
                mptr = ec;
            end
        end
        pop_lat = bus.in_pop;
    endtask

    // Rising edge: the ingress FIFOs act on the pop they saw and present the popped word.
    task automatic edge_();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_lat[i] && fq[i].size() > 0) dreg[i] = fq[i].pop_front();
        end
        pop_lat = 4'b0000;
        refresh();
    endtask

    task automatic adv();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_();
        edge_();
        adv();
    endtask

    task automatic wait_pop();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (bus.in_pop != 4'b0000) ok = 1'b1;
            else cyc_();
        end
        chk("pop_timeout", ok, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 80 && !ok; t++) begin
            if (bus.idle && empt == 4'hF && pend.size() == 0) ok = 1'b1;
            else cyc_();
        end
        chk("drain_idle", ok, 1);
    endtask

    task automatic do_reset();
        edge_();
        reset = 1'b0;
        adv();
        cyc_();
        cyc_();
        edge_();
        reset = 1'b1;
        adv();
        chk("init_idle", bus.idle, 0);
        chk("init_pop", bus.in_pop, 0);
        cyc_();
        chk("post_init_idle", bus.idle, 1);
        chk("post_init_count", bus.fwd_count, 0);
    endtask

    initial begin : stim
        logic [1:0] g [5];
        logic [1:0] exp_g [5];
        logic [3:0] rp [4];
        logic [9:0] rd [4];
        logic [3:0] exp_rp [4];
        logic [9:0] exp_rd [4];
        logic [7:0] base;
        int         ng;
        int         np;
        int         npush;

        nvec  = 0;
        nfail = 0;
        cyc   = 0;
        mcnt  = 8'd0;
        mptr  = 3;
        reset = 1'b0;
        afull = 4'b0000;
        pop_lat = 4'b0000;
        for (int i = 0; i < 4; i++) dreg[i] = 10'd0;
        refresh();

        // Reset held for three cycles, then one INIT cycle before IDLE.
        adv();
        chk("rst_idle", bus.idle, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_data", bus.out_data, 0);
        cyc_();
        cyc_();
        edge_();
        reset = 1'b1;
        adv();
        chk("init_idle", bus.idle, 0);
        chk("init_push", bus.out_push, 0);
        cyc_();
        chk("idle_after_init", bus.idle, 1);
        chk("idle_pop", bus.in_pop, 0);
        chk("idle_count", bus.fwd_count, 0);

        // Single word from FIFO2 with destination 1.
        edge_();
        load(2, 10'b01_0000_0101);
        adv();
        chk("sw_no_pop_in_idle", bus.in_pop, 0);
        cyc_();
        chk("sw_pop", bus.in_pop, 4'b0100);
        chk("sw_grant", bus.grant, 2);
        cyc_();
        chk("sw_pop_done", bus.in_pop, 0);
        chk("sw_grant_hold", bus.grant, 2);
        cyc_();
        chk("sw_push", bus.out_push, 4'b0010);
        chk("sw_data", bus.out_data, 10'h105);
        chk("sw_count", bus.fwd_count, 1);
        drain();

        // Arbitration with every FIFO holding two words.
        do_reset();
        edge_();
        for (int i = 0; i < 4; i++) begin
            load(i, {2'b00, 4'(i), 4'd0});
            load(i, {2'b00, 4'(i), 4'd1});
        end
        adv();
        ng = 0;
        for (int t = 0; t < 30 && ng < 5; t++) begin
            cyc_();
            if (bus.in_pop != 4'b0000) begin
                g[ng] = bus.grant;
                ng++;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        exp_g = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
`endif
        chk("arb_count", ng, 5);
        for (int i = 0; i < 5 && i < ng; i++) chk($sformatf("arb_grant%0d", i), g[i], exp_g[i]);
        drain();

        // Destination routing from FIFO0.
        edge_();
        load(0, 10'h001);
        load(0, 10'h302);
        load(0, 10'h203);
        load(0, 10'h104);
        adv();
        np = 0;
        for (int t = 0; t < 30 && np < 4; t++) begin
            cyc_();
            if (bus.out_push != 4'b0000) begin
                rp[np] = bus.out_push;
                rd[np] = bus.out_data;
                np++;
            end
        end
        exp_rp = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
        exp_rd = '{10'h001, 10'h302, 10'h203, 10'h104};
        chk("route_count", np, 4);
        for (int i = 0; i < 4 && i < np; i++) begin
            chk($sformatf("route_push%0d", i), rp[i], exp_rp[i]);
            chk($sformatf("route_data%0d", i), rd[i], exp_rd[i]);
        end
        drain();

        // Backpressure on egress 3 during a six-word stream.
        base = bus.fwd_count;
        edge_();
        for (int i = 0; i < 6; i++) load(1, 10'h300 + 10'(i));
        adv();
        wait_pop();
        edge_();
        afull = 4'b1000;
        adv();
        chk("bp_stop", bus.in_pop, 0);
        npush = (bus.out_push != 4'b0000) ? 1 : 0;
        for (int t = 0; t < 3; t++) begin
            cyc_();
            chk("bp_hold", bus.in_pop, 0);
            if (bus.out_push != 4'b0000) npush++;
        end
        chk("bp_inflight_le2", (npush <= 2) ? 1 : 0, 1);
        edge_();
        afull = 4'b0000;
        adv();
        chk("bp_resume", bus.in_pop, 4'b0010);
        drain();
        chk("bp_total", 8'(bus.fwd_count - base), 6);

        // Reset while one word is being pushed and another is in flight.
        edge_();
        load(3, 10'h2AA);
        load(3, 10'h255);
        adv();
        wait_pop();
        cyc_();
        edge_();
        chk("ms_push_before", bus.out_push, 4'b0100);
        reset = 1'b0;
        #1;
        chk("ms_push_drop", bus.out_push, 0);
        chk("ms_count_clear", bus.fwd_count, 0);
        chk("ms_pop_clear", bus.in_pop, 0);
        adv();
        cyc_();
        edge_();
        reset = 1'b1;
        adv();
        chk("ms_init", bus.idle, 0);
        for (int t = 0; t < 4; t++) begin
            cyc_();
            chk("ms_no_push", bus.out_push, 0);
        end
        chk("ms_idle", bus.idle, 1);
        chk("ms_count", bus.fwd_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
